kmkz_ahb_sram_slave: RTL and testbench

AHB-Lite slave for the core's data-memory bus. It terminates the load/store transfers the writeback stage issues and waits on through HREADY/HRDATA. It wraps a word-organised SRAM array with byte-lane writes, programmable wait states and read-after-write forwarding. It returns the full 32-bit word on HRDATA; the master performs lane extraction.

---
 rtl/kmkz_ahb_sram_slave_if.sv | 23 ++
 rtl/kmkz_ahb_sram_slave.sv | 169 ++++++++++++++++
 tb/tb_kmkz_ahb_sram_slave.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/kmkz_ahb_sram_slave_if.sv
// rtl/kmkz_ahb_sram_slave_if.sv - AHB-Lite bus bundle between the data-memory master and the SRAM slave
interface kmkz_ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/kmkz_ahb_sram_slave.sv
// rtl/kmkz_ahb_sram_slave.sv - AHB-Lite SRAM slave with byte lanes, wait states and write forwarding (optional KMKZ_SRAM_ERR_EN)
module kmkz_ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  kmkz_ahb_sram_slave_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           mem [DEPTH];
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic                  a_write;
  logic [3:0]            a_be;
  logic [31:0]           rd_buf;
  logic [31:0]           hrdata_q;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic [3:0]            req_be;
  logic                  req_err;
  logic                  phase_end;
  logic                  take;
  logic                  commit;
  logic                  fwd_hit;
  logic [31:0]           rd_word;
  logic                  ready_c;

  // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ, which is irrelevant here
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

  assign req_idx = bus.HADDR[ADDR_WIDTH+1:2];

  // A new address phase can only be taken in a cycle where the previous data phase is ending
  assign phase_end = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign take      = bus.HSEL & bus.HTRANS[1] & bus.HREADY & phase_end;
  assign commit    = (state == S_DATA) & a_write;
  assign fwd_hit   = commit & (a_idx == req_idx);

  // Byte-lane mask from size and low address bits; oversize transfers fall back to a full word
  always_comb begin
    req_be = 4'b1111;
    case (bus.HSIZE)
      3'd0:    req_be = 4'b0001 << bus.HADDR[1:0];
      3'd1:    req_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase
  end

`ifdef KMKZ_SRAM_ERR_EN
  assign req_err = (bus.HSIZE > 3'd2) ||
                   ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                   ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  // Array word for a newly accepted read, merged with lanes being committed on the same edge
  always_comb begin
    rd_word = mem[req_idx];
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit && a_be[i]) begin
        rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Next-state and ready decode
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b1;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (take) begin
          if (req_err) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        ready_c = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = S_DATA;
        end
      end
      S_ERR1: begin
        ready_c   = 1'b0;
        state_nxt = S_ERR2;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, address-phase capture, wait counter and read-data registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      a_idx    <= '0;
      a_write  <= 1'b0;
      a_be     <= 4'b0000;
      rd_buf   <= 32'd0;
      hrdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        a_idx   <= req_idx;
        a_write <= bus.HWRITE & ~req_err;
        a_be    <= req_be;
        cnt     <= WS_LOAD;
        if (!bus.HWRITE && !req_err) begin
          // Zero-wait reads must present data in the very next cycle
          if (WAIT_STATES == 0) begin
            hrdata_q <= rd_word;
          end else begin
            rd_buf <= rd_word;
          end
        end
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == S_WAIT) && (cnt == 4'd0) && !a_write) begin
        hrdata_q <= rd_buf;
      end
    end
  end

  // Array write port: enabled lanes land on the edge that closes the write data phase
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = ready_c;
  assign bus.HRDATA    = hrdata_q;
`ifdef KMKZ_SRAM_ERR_EN
  assign bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);
`else
  assign bus.HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_kmkz_ahb_sram_slave.sv
// tb/tb_kmkz_ahb_sram_slave.sv - directed bench for kmkz_ahb_sram_slave (zero-wait, 2-wait/4-bit, 3-wait instances)
module tb_kmkz_ahb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          cur;
  int          checks;
  int          errors;

  kmkz_ahb_sram_slave_if b0 ();
  kmkz_ahb_sram_slave_if b2 ();
  kmkz_ahb_sram_slave_if b3 ();

  assign b0.HSEL = sel[0];
  assign b2.HSEL = sel[1];
  assign b3.HSEL = sel[2];
  assign b0.HADDR = haddr;  assign b2.HADDR = haddr;  assign b3.HADDR = haddr;
  assign b0.HTRANS = htrans; assign b2.HTRANS = htrans; assign b3.HTRANS = htrans;
  assign b0.HWRITE = hwrite; assign b2.HWRITE = hwrite; assign b3.HWRITE = hwrite;
  assign b0.HSIZE = hsize;  assign b2.HSIZE = hsize;  assign b3.HSIZE = hsize;
  assign b0.HWDATA = hwdata; assign b2.HWDATA = hwdata; assign b3.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b2.HREADY = b2.HREADYOUT;
  assign b3.HREADY = b3.HREADYOUT;

  kmkz_ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (.clk_i(clk), .rst_i(rst_n), .bus(b0.slave));
  kmkz_ahb_sram_slave #(.ADDR_WIDTH(4),  .WAIT_STATES(2)) u2 (.clk_i(clk), .rst_i(rst_n), .bus(b2.slave));
  kmkz_ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (.clk_i(clk), .rst_i(rst_n), .bus(b3.slave));

  logic        ro;
  logic        rs;
  logic [31:0] rd;
  assign ro = (cur == 0) ? b0.HREADYOUT : (cur == 1) ? b2.HREADYOUT : b3.HREADYOUT;
  assign rs = (cur == 0) ? b0.HRESP     : (cur == 1) ? b2.HRESP     : b3.HRESP;
  assign rd = (cur == 0) ? b0.HRDATA    : (cur == 1) ? b2.HRDATA    : b3.HRDATA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input int d, input logic [31:0] a, input logic w, input logic [2:0] s);
    cur    = d;
    sel    = 3'b001 << d;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic idle_bus();
    sel    = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic wait_ready(output int waits);
    waits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ro) break;
      waits++;
    end
    if (!ro) chk("ready_timeout", {31'd0, ro}, 32'd1);
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] data);
    int w;
    addr_ph(d, a, 1'b1, s);
    @(posedge clk); #1;
    idle_bus();
    hwdata = data;
    wait_ready(w);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [2:0] s,
                         output logic [31:0] data, output int waits, output logic resp);
    addr_ph(d, a, 1'b0, s);
    @(posedge clk); #1;
    idle_bus();
    wait_ready(waits);
    data = rd;
    resp = rs;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] data;
    int          waits;
    logic        resp;
    checks = 0;
    errors = 0;
    cur    = 0;
    rst_n  = 1'b0;
    hwdata = 32'd0;
    haddr  = 32'd0;
    hsize  = 3'd0;
    idle_bus();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_u0", {31'd0, b0.HREADYOUT}, 32'd1);
    chk("rst_resp_u0", {31'd0, b0.HRESP}, 32'd0);
    chk("rst_rdata_u0", b0.HRDATA, 32'd0);
    chk("rst_ready_u3", {31'd0, b3.HREADYOUT}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write then back-to-back read of the same word (forwarded)
    addr_ph(0, 32'h10, 1'b1, 3'd2);
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF;
    addr_ph(0, 32'h10, 1'b0, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("b2b_ready", {31'd0, ro}, 32'd1);
    chk("b2b_fwd_data", rd, 32'hDEADBEEF);
    @(posedge clk); #1;

    // byte and halfword lane writes
    do_write(0, 32'h10, 3'd2, 32'h11223344);
    do_write(0, 32'h13, 3'd0, 32'hAA000000);
    do_read(0, 32'h10, 3'd2, data, waits, resp);
    chk("byte_write", data, 32'hAA223344);
    chk("zero_wait", waits, 0);
    do_write(0, 32'h12, 3'd1, 32'h55660000);
    do_read(0, 32'h10, 3'd2, data, waits, resp);
    chk("half_write", data, 32'h55663344);

    // partial write forwarded into an immediately following read
    addr_ph(0, 32'h11, 1'b1, 3'd0);
    @(posedge clk); #1;
    hwdata = 32'h00007700;
    addr_ph(0, 32'h10, 1'b0, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("partial_fwd", rd, 32'h55667744);
    @(posedge clk); #1;

    // two wait states, single and pipelined reads
    do_write(1, 32'h04, 3'd2, 32'hCAFE0001);
    do_write(1, 32'h08, 3'd2, 32'hCAFE0002);
    do_read(1, 32'h04, 3'd2, data, waits, resp);
    chk("ws2_waits", waits, 2);
    chk("ws2_data", data, 32'hCAFE0001);
    addr_ph(1, 32'h04, 1'b0, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    wait_ready(waits);
    chk("pipe1_waits", waits, 2);
    chk("pipe1_data", rd, 32'hCAFE0001);
    addr_ph(1, 32'h08, 1'b0, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    wait_ready(waits);
    chk("pipe2_waits", waits, 2);
    chk("pipe2_data", rd, 32'hCAFE0002);
    @(posedge clk); #1;

    // aliasing with a 16-word array
    do_write(1, 32'h00, 3'd2, 32'h1);
    do_write(1, 32'h40, 3'd2, 32'h2);
    do_read(1, 32'h00, 3'd2, data, waits, resp);
    chk("alias", data, 32'h2);

    // reset in the middle of a write's wait states
    do_write(2, 32'h20, 3'd2, 32'h12345678);
    addr_ph(2, 32'h20, 1'b1, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("midwait_busy", {31'd0, ro}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_ready", {31'd0, ro}, 32'd1);
    chk("midwait_rst_resp", {31'd0, rs}, 32'd0);
    chk("midwait_rst_rdata", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(2, 32'h20, 3'd2, data, waits, resp);
    chk("midwait_no_commit", data, 32'h12345678);
    chk("ws3_waits", waits, 3);

    // misaligned word accesses
    do_write(0, 32'h00, 3'd2, 32'h0BADF00D);
    addr_ph(0, 32'h02, 1'b0, 3'd2);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
`ifdef KMKZ_SRAM_ERR_EN
    chk("err1_ready", {31'd0, ro}, 32'd0);
    chk("err1_resp", {31'd0, rs}, 32'd1);
    @(negedge clk);
    chk("err2_ready", {31'd0, ro}, 32'd1);
    chk("err2_resp", {31'd0, rs}, 32'd1);
`else
    chk("misalign_ready", {31'd0, ro}, 32'd1);
    chk("misalign_resp", {31'd0, rs}, 32'd0);
    chk("misalign_data", rd, 32'h0BADF00D);
`endif
    @(posedge clk); #1;
    do_write(0, 32'h12, 3'd2, 32'h00000000);
    do_read(0, 32'h10, 3'd2, data, waits, resp);
`ifdef KMKZ_SRAM_ERR_EN
    chk("err_write_blocked", data, 32'h55667744);
`else
    chk("misalign_write", data, 32'h00000000);
`endif
    do_read(0, 32'h00, 3'd2, data, waits, resp);
    chk("word0_intact", data, 32'h0BADF00D);
    chk("word0_resp", {31'd0, resp}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
